// File: rtl/operand_loader.sv
// operand_loader
//   Writer side of the ALU operand store. Two banks (A, B) of DEPTH x WIDTH
//   words are loaded one word per debounced press of btn_write, using the
//   board switches for data, address and bank select. A press of btn_clear
//   zero-fills both banks with a DEPTH-cycle sweep. A reset also starts that
//   sweep.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   sw_data/sw_addr      word and target address to write
//   sel_b                bank select (0 = A, 1 = B)
//   btn_write/btn_clear  raw asynchronous, bouncy buttons
//   address_a/address_b  read addresses for bank A and bank B
//   data_a/data_b        combinational read data
//   busy                 high while a write or clear sweep is in progress
//   write_done           one-cycle pulse in the first cycle the new word is visible
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for a clear or write request
//   S_WRITE | captured word is written on this cycle's edge
//   S_CLEAR | zeroing A[idx] and B[idx], one entry per cycle
module operand_loader #(
  parameter int WIDTH           = 16,
  parameter int DEPTH           = 32,
  parameter int ADDR_W          = 5,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sw_data,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              sel_b,
  input  logic              btn_write,
  input  logic              btn_clear,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  output logic [WIDTH-1:0]  data_a,
  output logic [WIDTH-1:0]  data_b,
  output logic              busy,
  output logic              write_done
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------
  // Button conditioning, bit 0 = write button, bit 1 = clear button
  // ---------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       req_q, req_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign btn_raw = {btn_clear, btn_write};

  always_comb begin
    deb_d = deb_q;
    req_d = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
          // only a 0->1 transition of the debounced level makes a request
          req_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      req_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    waddr   = addr_q;
    wdata   = data_q;
    unique case (state_q)
      S_IDLE: begin
        // a simultaneous write request is dropped in favour of the clear
        if (req_q[1]) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (req_q[0]) begin
          data_d  = sw_data;
          addr_d  = sw_addr;
          sel_d   = sel_b;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        we_a    = ~sel_q;
        we_b    = sel_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        we_a  = 1'b1;
        we_b  = 1'b1;
        waddr = idx_q;
        wdata = '0;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == IDX_LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Operand banks; no writes while rst is high so a reset aborts a write
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_a) mem_a_q[waddr] <= wdata;
      if (we_b) mem_b_q[waddr] <= wdata;
    end
  end

  assign data_a     = mem_a_q[address_a];
  assign data_b     = mem_b_q[address_b];
  assign busy       = (state_q != S_IDLE);
  assign write_done = done_q;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Writer side of the ALU operand store: a user-programmable replacement for the hard-coded operand tables.
- Holds two banks (A and B) of DEPTH x WIDTH words.
- Loads one word per debounced button press from board switches; a second button zero-fills both banks.
- Exposes two asynchronous read ports that feed the ALU x/y inputs.

Parameters:
- WIDTH, 16, operand word width.
- DEPTH, 32, words per bank.
- ADDR_W, 5, address width; must equal clog2(DEPTH).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sw_data  input  WIDTH  word to write.
- sw_addr  input  ADDR_W  target address.
- sel_b  input  1  bank select: 0 = bank A, 1 = bank B.
- btn_write  input  1  raw write button, asynchronous and bouncy.
- btn_clear  input  1  raw clear button, asynchronous and bouncy.
- address_a  input  ADDR_W  read address, bank A.
- address_b  input  ADDR_W  read address, bank B.
- data_a  output  WIDTH  bank A word at address_a, combinational.
- data_b  output  WIDTH  bank B word at address_b, combinational.
- busy  output  1  high while a clear sweep or write is in progress.
- write_done  output  1  one-cycle pulse after a completed write.

Behaviour:
- Button conditioning (identical per button):
  - 2-flop synchronizer, then debouncer.
  - Counter increments while the synced level differs from the debounced level; it resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level toggles and the counter clears.
  - A rising edge of the debounced level produces a one-cycle request (wr_req or clr_req). Falling edges produce nothing.
  - Latency from a clean press to the request: 2 + DEBOUNCE_CYCLES cycles, ±1.
- FSM states: IDLE, WRITE, CLEAR.
  - IDLE, clr_req: go to CLEAR, clear index = 0. Clear takes priority if wr_req arrives in the same cycle; that wr_req is dropped.
  - IDLE, wr_req: register sw_data, sw_addr and sel_b in that cycle, then go to WRITE.
  - WRITE: write the captured word into the selected bank at the captured address on this cycle's edge, then go to IDLE.
    - write_done is high for exactly the following cycle, the first cycle in which the new word is visible on data_a/data_b.
    - The other bank is untouched.
  - CLEAR: each cycle, write 0 to A[idx] and B[idx] and increment idx. After idx = DEPTH-1 is written, go to IDLE; the sweep is DEPTH cycles.
  - Requests arriving in WRITE or CLEAR are dropped, not queued.
- busy = 1 in WRITE and CLEAR, 0 in IDLE.
- Switch inputs are sampled only in the wr_req cycle; changes afterwards do not affect the write in flight.
- Reads:
  - data_a = A[address_a] and data_b = B[address_b], purely combinational.
  - Valid in every state. During CLEAR, already-swept entries read 0 and unswept entries hold their old contents.
- Reset (rst high on a clock edge):
  - FSM forced to CLEAR with idx = 0.
  - Debouncer counters cleared; debounced levels = 0.
  - Pending requests and captured registers cleared; write_done = 0, busy = 1.
  - The clear sweep starts on the first cycle after rst deasserts.
  - Reset mid-WRITE aborts the write; the sweep then zeroes everything regardless.
  - Reset mid-CLEAR restarts the sweep at idx 0.
  - Bank contents before the first completed sweep are undefined and must not be relied on.
- Address wrap: all addresses are ADDR_W bits, so DEPTH = 2^ADDR_W and no out-of-range case exists.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset for 3 cycles, then release -> busy = 1 for exactly 32 cycles, then 0; every A/B entry reads 16'h0000; write_done never pulses.
- sw_data = 16'h7FFF, sw_addr = 11, sel_b = 0, clean btn_write press held for 10 cycles -> single write_done pulse; data_a at address 11 = 16'h7FFF; data_b at address 11 = 16'h0000; busy high for exactly 1 cycle.
- btn_write chatter (toggle every 2 cycles for 12 cycles, then stay high), sw_data = 16'hFFF8, sw_addr = 15, sel_b = 1 -> exactly one write_done; B[15] = 16'hFFF8.
- Change sw_data from 16'h5555 to 16'hAAAA one cycle after wr_req -> written word = 16'h5555.
- After filling A[0..31] with 16'hA5A5, press btn_clear, then press btn_write during the sweep -> all entries read 0 after 32 cycles; no write_done; the write is not performed after the sweep.
- Press both buttons with identical timing (both requests in the same cycle) -> clear executes, write dropped. Separately, assert rst at cycle 10 of a sweep -> sweep restarts and busy stays high for 32 cycles after release.
